// File: rtl/rti_pop_sequencer.sv
// ---------------------------------------------------------------------------
// rti_pop_sequencer
//
// Multi-cycle return-from-interrupt sequencer. This is the read-back end of
// the interrupt-entry push. When an RTI is accepted, it pops three words from
// the data-memory stack through a req/ack read port:
//   the saved flags, then the upper PC word, then the lower PC word.
// While it does this it stalls the pipeline. In one final COMMIT cycle it
// strobes the restored PC, flags and SP into the architectural registers.
//
// Stack layout, ascending from the latched SP value S:
//   S+1 flags, S+2 PC high word, S+3 PC low word.
// Address arithmetic wraps modulo 2^ADDR_W.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   rti_start   one-cycle RTI request from decode (ignored while busy)
//   sp_in       current SP, latched when an RTI is accepted
//   mem_req     read request, held with a stable mem_addr until mem_ack
//   mem_addr    read address
//   mem_rdata   read data, valid when mem_ack is high
//   mem_ack     read complete on this rising edge (ignored without mem_req)
//   stall       freeze fetch/decode; same as busy
//   busy        sequencer is not idle
//   pc_out      restored PC {hi, lo}, held until the next commit
//   pc_load     one-cycle PC load strobe
//   flags_out   restored flags, held until the next commit
//   flags_load  one-cycle flags load strobe
//   sp_out      restored SP = S + 3, held until the next commit
//   sp_load     one-cycle SP load strobe
//   done        one-cycle completion strobe
// ---------------------------------------------------------------------------
module rti_pop_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int FLAG_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rti_start,
  input  logic [ADDR_W-1:0]   sp_in,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall,
  output logic                busy,
  output logic [2*DATA_W-1:0] pc_out,
  output logic                pc_load,
  output logic [FLAG_W-1:0]   flags_out,
  output logic                flags_load,
  output logic [ADDR_W-1:0]   sp_out,
  output logic                sp_load,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP_FLAGS = 3'd1,
    POP_PC_HI = 3'd2,
    POP_PC_LO = 3'd3,
    COMMIT    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [FLAG_W-1:0]     flags_word_q, flags_word_d;
  logic [DATA_W-1:0]     pc_hi_q, pc_hi_d;

  logic                  mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic                  commit_q, commit_d;
  logic [2*DATA_W-1:0]   pc_out_q, pc_out_d;
  logic [FLAG_W-1:0]     flags_out_q, flags_out_d;
  logic [ADDR_W-1:0]     sp_out_q, sp_out_d;

  // Next-state and next-output logic. Every output is registered, so the
  // request/address/strobe values are computed here from the state being
  // entered (state_d) rather than the current one. That way mem_addr is
  // already correct in the first cycle of each pop. The PC low word is never
  // stored separately: it goes straight into pc_out on the edge that ends the
  // last pop, so the restored values are visible in the COMMIT cycle.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    flags_word_d = flags_word_q;
    pc_hi_d      = pc_hi_q;
    pc_out_d     = pc_out_q;
    flags_out_d  = flags_out_q;
    sp_out_d     = sp_out_q;
    commit_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rti_start) begin
          base_d  = sp_in;
          state_d = POP_FLAGS;
        end
      end
      POP_FLAGS: begin
        if (mem_ack) begin
          flags_word_d = mem_rdata[FLAG_W-1:0];
          state_d      = POP_PC_HI;
        end
      end
      POP_PC_HI: begin
        if (mem_ack) begin
          pc_hi_d = mem_rdata;
          state_d = POP_PC_LO;
        end
      end
      POP_PC_LO: begin
        if (mem_ack) begin
          pc_out_d    = {pc_hi_q, mem_rdata};
          flags_out_d = flags_word_q;
          sp_out_d    = base_q + ADDR_W'(3);
          commit_d    = 1'b1;
          state_d     = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d    = (state_d != IDLE);
    mem_req_d = (state_d == POP_FLAGS) || (state_d == POP_PC_HI) ||
                (state_d == POP_PC_LO);

    case (state_d)
      POP_FLAGS: mem_addr_d = base_d + ADDR_W'(1);
      POP_PC_HI: mem_addr_d = base_d + ADDR_W'(2);
      POP_PC_LO: mem_addr_d = base_d + ADDR_W'(3);
      default:   mem_addr_d = '0;
    endcase
  end

  // State and output registers. Reset is synchronous. It clears all partial
  // data and every output, so an RTI interrupted by reset leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      flags_word_q <= '0;
      pc_hi_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      commit_q     <= 1'b0;
      pc_out_q     <= '0;
      flags_out_q  <= '0;
      sp_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      flags_word_q <= flags_word_d;
      pc_hi_q      <= pc_hi_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      commit_q     <= commit_d;
      pc_out_q     <= pc_out_d;
      flags_out_q  <= flags_out_d;
      sp_out_q     <= sp_out_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign stall      = busy_q;
  assign pc_out     = pc_out_q;
  assign flags_out  = flags_out_q;
  assign sp_out     = sp_out_q;
  assign pc_load    = commit_q;
  assign flags_load = commit_q;
  assign sp_load    = commit_q;
  assign done       = commit_q;

endmodule
